// File: rtl/rd_ptr_pkg.sv
// Shared constants, pointer types and Gray/binary helpers for the FIFO read side.
// The helpers operate on a wide pointer type; callers zero-extend narrower
// pointers in and size-cast the result back, which is exact for both directions.
package rd_ptr_pkg;

    localparam int PTR_WIDTH_DEF = 3;
    localparam int PTR_W_MAX     = 15;

    typedef logic [PTR_WIDTH_DEF:0] ptr_t;
    typedef logic [PTR_W_MAX:0]     ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return (b >> 1) ^ b;
    endfunction

    // MSB passes through; every lower bit is the XOR of itself and all bits above.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b[PTR_W_MAX] = g[PTR_W_MAX];
        for (int i = PTR_W_MAX - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rd_ptr_ctrl_if.sv
// Read-side control bus between the FIFO read logic and its user/memory.
interface rd_ptr_ctrl_if #(
    parameter int PTR_WIDTH = rd_ptr_pkg::PTR_WIDTH_DEF
);
    logic                 r_en;
    logic [PTR_WIDTH:0]   g_wptr_sync;
    logic [PTR_WIDTH:0]   ae_thresh;
    logic                 uf_clr;
    logic [PTR_WIDTH:0]   b_rptr;
    logic [PTR_WIDTH:0]   g_rptr;
    logic [PTR_WIDTH-1:0] raddr;
    logic                 empty;
    logic                 almost_empty;
    logic [PTR_WIDTH:0]   rcount;
    logic                 underflow;
    logic                 rd_ack;

    modport master (
        output r_en, g_wptr_sync, ae_thresh, uf_clr,
        input  b_rptr, g_rptr, raddr, empty, almost_empty, rcount, underflow, rd_ack
    );

    modport slave (
        input  r_en, g_wptr_sync, ae_thresh, uf_clr,
        output b_rptr, g_rptr, raddr, empty, almost_empty, rcount, underflow, rd_ack
    );
endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter for a W-bit pointer.
module gray2bin
    import rd_ptr_pkg::*;
#(
    parameter int W = PTR_WIDTH_DEF + 1
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Widen into the package helper and size-cast the result back down.
    always_comb begin
        bin = W'(rd_ptr_pkg::gray2bin(ptr_max_t'(gray)));
    end

endmodule

// File: rtl/rd_ptr_ctrl.sv
// FIFO read-pointer controller: binary/Gray read pointers, empty and
// almost-empty flags, fill level, sticky underflow and read acknowledge.
module rd_ptr_ctrl
    import rd_ptr_pkg::*;
#(
    parameter int PTR_WIDTH = PTR_WIDTH_DEF
) (
    input  logic          rclk,
    input  logic          rrst,
    rd_ptr_ctrl_if.slave  bus
);

    localparam int PW = PTR_WIDTH + 1;

    logic [PTR_WIDTH:0] b_rptr_q, b_rptr_d;
    logic [PTR_WIDTH:0] g_rptr_q, g_rptr_d;
    logic [PTR_WIDTH:0] rcount_q, rcount_d;
    logic               empty_q, empty_d;
    logic               almost_empty_q, almost_empty_d;
    logic               underflow_q, underflow_d;
    logic               rd_ack_q, rd_ack_d;

    logic               rd_go;
    logic [PTR_WIDTH:0] b_wptr;
    logic [PTR_WIDTH:0] fill_next;

    gray2bin #(.W(PW)) u_wptr_g2b (
        .gray (bus.g_wptr_sync),
        .bin  (b_wptr)
    );

    // Next-state: the read advance and the synced write pointer both feed the
    // same fill computation, so simultaneous activity needs no arbitration.
    always_comb begin
        rd_go          = bus.r_en & ~empty_q;
        b_rptr_d       = b_rptr_q + {{PTR_WIDTH{1'b0}}, rd_go};
        g_rptr_d       = PW'(bin2gray(ptr_max_t'(b_rptr_d)));
        fill_next      = b_wptr - b_rptr_d;
        empty_d        = (bus.g_wptr_sync == g_rptr_d);
        rcount_d       = fill_next;
        almost_empty_d = (fill_next <= bus.ae_thresh);
        // A fresh underflow outranks a clear in the same cycle.
        underflow_d    = (bus.r_en & empty_q) | (underflow_q & ~bus.uf_clr);
        rd_ack_d       = rd_go;
    end

    // State registers; the FIFO reads as empty while held in reset.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            b_rptr_q       <= '0;
            g_rptr_q       <= '0;
            rcount_q       <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            underflow_q    <= 1'b0;
            rd_ack_q       <= 1'b0;
        end else begin
            b_rptr_q       <= b_rptr_d;
            g_rptr_q       <= g_rptr_d;
            rcount_q       <= rcount_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            underflow_q    <= underflow_d;
            rd_ack_q       <= rd_ack_d;
        end
    end

    assign bus.b_rptr       = b_rptr_q;
    assign bus.g_rptr       = g_rptr_q;
    assign bus.raddr        = b_rptr_q[PTR_WIDTH-1:0];
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.rcount       = rcount_q;
    assign bus.underflow    = underflow_q;
    assign bus.rd_ack       = rd_ack_q;

endmodule

// File: tb/tb_rd_ptr_ctrl.sv
// Directed bench for rd_ptr_ctrl with PTR_WIDTH = 3.
module tb_rd_ptr_ctrl;

    logic rclk = 1'b0;
    logic rrst;
    int   n_cmp = 0;
    int   n_bad = 0;

    // 4-bit Gray code, indexed by binary value.
    logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    rd_ptr_ctrl_if #(.PTR_WIDTH(3)) bus ();

    rd_ptr_ctrl #(.PTR_WIDTH(3)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus.slave)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".b_rptr"}, 8'(bus.b_rptr), 8'h0);
        chk({tag, ".g_rptr"}, 8'(bus.g_rptr), 8'h0);
        chk({tag, ".raddr"}, 8'(bus.raddr), 8'h0);
        chk({tag, ".empty"}, 8'(bus.empty), 8'h1);
        chk({tag, ".almost_empty"}, 8'(bus.almost_empty), 8'h1);
        chk({tag, ".rcount"}, 8'(bus.rcount), 8'h0);
        chk({tag, ".underflow"}, 8'(bus.underflow), 8'h0);
        chk({tag, ".rd_ack"}, 8'(bus.rd_ack), 8'h0);
    endtask

    initial begin
        logic [3:0] wbin;
        logic [3:0] bexp;

        // Reset held with active inputs: everything must stay at reset values.
        rrst = 1'b1;
        bus.r_en = 1'b1;
        bus.g_wptr_sync = 4'b0010;
        bus.ae_thresh = 4'd2;
        bus.uf_clr = 1'b0;
        step();
        step();
        chk_reset_vals("rst");

        rrst = 1'b0;
        bus.r_en = 1'b0;
        step();
        chk("rel.empty", 8'(bus.empty), 8'h0);
        chk("rel.rcount", 8'(bus.rcount), 8'h3);
        chk("rel.almost_empty", 8'(bus.almost_empty), 8'h0);
        chk("rel.underflow", 8'(bus.underflow), 8'h0);

        // Drain three words, then one read against an empty FIFO.
        bus.r_en = 1'b1;
        step();
        chk("drain1.rd_ack", 8'(bus.rd_ack), 8'h1);
        chk("drain1.b_rptr", 8'(bus.b_rptr), 8'h1);
        chk("drain1.g_rptr", 8'(bus.g_rptr), 8'h1);
        chk("drain1.rcount", 8'(bus.rcount), 8'h2);
        chk("drain1.almost_empty", 8'(bus.almost_empty), 8'h1);
        chk("drain1.empty", 8'(bus.empty), 8'h0);
        step();
        chk("drain2.rd_ack", 8'(bus.rd_ack), 8'h1);
        chk("drain2.g_rptr", 8'(bus.g_rptr), 8'h3);
        chk("drain2.rcount", 8'(bus.rcount), 8'h1);
        chk("drain2.empty", 8'(bus.empty), 8'h0);
        step();
        chk("drain3.rd_ack", 8'(bus.rd_ack), 8'h1);
        chk("drain3.b_rptr", 8'(bus.b_rptr), 8'h3);
        chk("drain3.g_rptr", 8'(bus.g_rptr), 8'h2);
        chk("drain3.empty", 8'(bus.empty), 8'h1);
        chk("drain3.rcount", 8'(bus.rcount), 8'h0);
        chk("drain3.underflow", 8'(bus.underflow), 8'h0);
        step();
        chk("drain4.underflow", 8'(bus.underflow), 8'h1);
        chk("drain4.rd_ack", 8'(bus.rd_ack), 8'h0);
        chk("drain4.b_rptr", 8'(bus.b_rptr), 8'h3);
        chk("drain4.rcount", 8'(bus.rcount), 8'h0);

        // Underflow clear, then clear colliding with a new underflow.
        bus.r_en = 1'b0;
        bus.uf_clr = 1'b1;
        step();
        chk("ufclr.underflow", 8'(bus.underflow), 8'h0);
        bus.r_en = 1'b1;
        step();
        chk("ufset_wins.underflow", 8'(bus.underflow), 8'h1);
        chk("ufset_wins.b_rptr", 8'(bus.b_rptr), 8'h3);
        chk("ufset_wins.rd_ack", 8'(bus.rd_ack), 8'h0);
        bus.r_en = 1'b0;
        bus.uf_clr = 1'b0;
        step();
        chk("ufsticky.underflow", 8'(bus.underflow), 8'h1);

        // Asynchronous reset mid-operation: visible before any clock edge.
        @(posedge rclk);
        #2;
        rrst = 1'b1;
        #1;
        chk_reset_vals("async_rst");

        // Full FIFO: write pointer at binary 8, read pointer at 0.
        bus.g_wptr_sync = 4'b1100;
        bus.ae_thresh = 4'd2;
        step();
        rrst = 1'b0;
        step();
        chk("full.rcount", 8'(bus.rcount), 8'h8);
        chk("full.almost_empty", 8'(bus.almost_empty), 8'h0);
        chk("full.empty", 8'(bus.empty), 8'h0);
        bus.r_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("full5.rcount", 8'(bus.rcount), 8'h3);
        chk("full5.almost_empty", 8'(bus.almost_empty), 8'h0);
        step();
        chk("full6.rcount", 8'(bus.rcount), 8'h2);
        chk("full6.almost_empty", 8'(bus.almost_empty), 8'h1);
        chk("full6.b_rptr", 8'(bus.b_rptr), 8'h6);
        chk("full6.empty", 8'(bus.empty), 8'h0);

        // Read while the write pointer advances 8 -> 9.
        bus.g_wptr_sync = 4'b1101;
        step();
        chk("conc.rcount", 8'(bus.rcount), 8'h2);
        chk("conc.empty", 8'(bus.empty), 8'h0);
        chk("conc.b_rptr", 8'(bus.b_rptr), 8'h7);
        chk("conc.rd_ack", 8'(bus.rd_ack), 8'h1);

        // Sustained reads across the pointer wrap, write pointer stepping along.
        wbin = 4'd9;
        bexp = 4'd7;
        for (int i = 0; i < 12; i++) begin
            wbin = wbin + 4'd1;
            bexp = bexp + 4'd1;
            bus.g_wptr_sync = gray_tab[wbin];
            step();
            chk($sformatf("wrap%0d.b_rptr", i), 8'(bus.b_rptr), 8'(bexp));
            chk($sformatf("wrap%0d.g_rptr", i), 8'(bus.g_rptr), 8'(gray_tab[bexp]));
            chk($sformatf("wrap%0d.raddr", i), 8'(bus.raddr), 8'(bexp[2:0]));
            chk($sformatf("wrap%0d.empty", i), 8'(bus.empty), 8'h0);
            chk($sformatf("wrap%0d.rcount", i), 8'(bus.rcount), 8'h2);
            chk($sformatf("wrap%0d.rd_ack", i), 8'(bus.rd_ack), 8'h1);
        end
        chk("wrap_end.b_rptr", 8'(bus.b_rptr), 8'h3);

        // Threshold 0 tracks empty: two words left, so almost_empty drops.
        bus.r_en = 1'b0;
        bus.ae_thresh = 4'd0;
        step();
        chk("ae0.almost_empty", 8'(bus.almost_empty), 8'h0);
        bus.r_en = 1'b1;
        step();
        step();
        chk("ae0_drained.empty", 8'(bus.empty), 8'h1);
        chk("ae0_drained.almost_empty", 8'(bus.almost_empty), 8'h1);
        bus.r_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
